// File: rtl/systemizer_pkg.sv
// Shared FSM state type and width helpers for the systemizer front-end loader.
package systemizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_UNLOAD,
        ST_FIN
    } loader_state_t;

    function automatic int calc_sym_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int calc_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int calc_dw(input int m, input int block);
        return block * calc_sym_w(m);
    endfunction

    function automatic int calc_idx_w(input int block);
        return (block > 1) ? $clog2(block) : 1;
    endfunction

endpackage

// File: rtl/sym_unpacker.sv
// Holds one memory word read back from the systemizer and hands its symbols out LSB-first.
module sym_unpacker
    import systemizer_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int BLOCK = 4,
    localparam int DW = SYM_W * BLOCK,
    localparam int IW = calc_idx_w(BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DW-1:0]    load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_sym,
    output logic             drained
);

    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK - 1);

    logic [DW-1:0] word_q;
    logic [IW-1:0] idx_q;

    assign drained = out_valid && out_ready && (idx_q == LAST_IDX);

    // The word shifts right as symbols leave, so the next symbol always sits just above the LSB slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
        end else if (load) begin
            word_q    <= load_data;
            idx_q     <= '0;
            out_valid <= 1'b1;
            out_sym   <= load_data[SYM_W-1:0];
        end else if (out_valid && out_ready) begin
            if (idx_q == LAST_IDX) begin
                out_valid <= 1'b0;
            end else begin
                idx_q   <= idx_q + 1'b1;
                word_q  <= word_q >> SYM_W;
                out_sym <= word_q[SYM_W +: SYM_W];
            end
        end
    end

endmodule

// File: rtl/systemizer_loader.sv
// Packs a symbol stream into systemizer matrix memory, kicks the core, then streams the result back out.
// Optional feature: define SYSLOADER_RANGE_CHECK_EN to abort a job on an out-of-range input symbol.
module systemizer_loader
    import systemizer_pkg::*;
#(
    parameter int L     = 8,
    parameter int K     = 16,
    parameter int M     = 3,
    parameter int BLOCK = 4,
    localparam int SYM_W = calc_sym_w(M),
    localparam int WORDS = L * K / BLOCK,
    localparam int AW    = calc_aw(WORDS),
    localparam int DW    = calc_dw(M, BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             busy,
    output logic             job_done,
    output logic             job_fail,
    output logic             job_success,
    output logic             err_range,
    output logic             sys_start,
    input  logic             sys_done,
    input  logic             sys_fail,
    input  logic             sys_success,
    output logic             sys_wr_en,
    output logic [AW-1:0]    sys_wr_addr,
    output logic [DW-1:0]    sys_wr_data,
    output logic             sys_rd_en,
    output logic [AW-1:0]    sys_rd_addr,
    input  logic [DW-1:0]    sys_rd_data
);

    localparam int IW = calc_idx_w(BLOCK);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

    loader_state_t state;
    logic [IW-1:0] sym_cnt;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] rd_cnt;
    logic [DW-1:0] pack_q;
    logic [DW-1:0] pack_next;
    logic          rd_pending;
    logic          accept;
    logic          range_bad;
    logic          drained;

    assign accept    = in_valid && in_ready && (state == ST_LOAD);
    assign pack_next = {in_sym, pack_q[DW-1:SYM_W]};

`ifdef SYSLOADER_RANGE_CHECK_EN
    assign range_bad = (32'(in_sym) >= 32'(M));
`else
    assign range_bad = 1'b0;
`endif

    // Main job sequencer; every port it drives is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sym_cnt     <= '0;
            word_cnt    <= '0;
            rd_cnt      <= '0;
            pack_q      <= '0;
            rd_pending  <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            job_fail    <= 1'b0;
            job_success <= 1'b0;
            err_range   <= 1'b0;
            sys_start   <= 1'b0;
            sys_wr_en   <= 1'b0;
            sys_wr_addr <= '0;
            sys_wr_data <= '0;
            sys_rd_en   <= 1'b0;
            sys_rd_addr <= '0;
        end else begin
            sys_wr_en  <= 1'b0;
            sys_rd_en  <= 1'b0;
            sys_start  <= 1'b0;
            job_done   <= 1'b0;
            rd_pending <= sys_rd_en;

            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        state       <= ST_LOAD;
                        busy        <= 1'b1;
                        in_ready    <= 1'b1;
                        sym_cnt     <= '0;
                        word_cnt    <= '0;
                        job_fail    <= 1'b0;
                        job_success <= 1'b0;
                        err_range   <= 1'b0;
                    end
                end

                // A completed word is written the cycle after its last symbol, overlapping the next word.
                ST_LOAD: begin
                    if (accept) begin
                        if (range_bad) begin
                            err_range <= 1'b1;
                            job_fail  <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_FIN;
                        end else begin
                            pack_q <= pack_next;
                            if (sym_cnt == LAST_IDX) begin
                                sym_cnt     <= '0;
                                sys_wr_en   <= 1'b1;
                                sys_wr_addr <= word_cnt;
                                sys_wr_data <= pack_next;
                                if (word_cnt == LAST_WORD) begin
                                    in_ready <= 1'b0;
                                    state    <= ST_KICK;
                                end else begin
                                    word_cnt <= word_cnt + 1'b1;
                                end
                            end else begin
                                sym_cnt <= sym_cnt + 1'b1;
                            end
                        end
                    end
                end

                ST_KICK: begin
                    sys_start <= 1'b1;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sys_done) begin
                        job_fail    <= sys_fail;
                        job_success <= sys_success;
                        if (sys_fail) begin
                            state <= ST_FIN;
                        end else begin
                            state       <= ST_UNLOAD;
                            rd_cnt      <= '0;
                            sys_rd_en   <= 1'b1;
                            sys_rd_addr <= '0;
                        end
                    end
                end

                // The next read is only issued once the unpacker has handed out its last symbol.
                ST_UNLOAD: begin
                    if (drained) begin
                        if (rd_cnt == LAST_WORD) begin
                            state <= ST_FIN;
                        end else begin
                            rd_cnt      <= rd_cnt + 1'b1;
                            sys_rd_en   <= 1'b1;
                            sys_rd_addr <= rd_cnt + 1'b1;
                        end
                    end
                end

                ST_FIN: begin
                    job_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sym_unpacker #(
        .SYM_W (SYM_W),
        .BLOCK (BLOCK)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_pending),
        .load_data (sys_rd_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .drained   (drained)
    );

endmodule
